// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: FSM state encoding and default vectors.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } pc_state_e;

  localparam logic [31:0] DefaultResetVector = 32'h0040_0000;
  localparam logic [31:0] DefaultExcVector   = 32'h8000_0180;
  localparam int unsigned DefaultInc         = 4;

endpackage

// File: rtl/pc_sequencer_reg.sv
// pc_reg: N-bit register with asynchronous active-high reset to RESET_VAL and a load enable.
// Ports:
//   clk, reset - clock, async active-high reset
//   load       - 1 = capture d on the rising edge
//   d          - next value
//   q          - registered value
module pc_reg #(
  parameter int unsigned   N         = 32,
  parameter logic [N-1:0]  RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with BOOT/RUN/HALT control, branch/jump
// redirects, exception entry/return and a registered misalignment pulse.
// Ports:
//   clk, reset                   - clock, async active-high reset
//   enable                       - allow sequential advance (0 = stall)
//   branch_taken/branch_target   - branch redirect
//   jump/jump_target             - jump redirect
//   exc_req, eret                - exception entry / return
//   halt_req, resume             - enter / leave HALT
//   pc, pc_plus_inc, epc         - fetch address, pc + INC, saved exception PC
//   fetch_valid, misalign_err    - fetch qualifier, misaligned-redirect pulse
//   state                        - FSM state encoding
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned  N            = 32,
  parameter logic [N-1:0] RESET_VECTOR = N'(DefaultResetVector),
  parameter logic [N-1:0] EXC_VECTOR   = N'(DefaultExcVector),
  parameter int unsigned  INC          = DefaultInc
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         branch_taken,
  input  logic [N-1:0] branch_target,
  input  logic         jump,
  input  logic [N-1:0] jump_target,
  input  logic         exc_req,
  input  logic         eret,
  input  logic         halt_req,
  input  logic         resume,
  output logic [N-1:0] pc,
  output logic [N-1:0] pc_plus_inc,
  output logic [N-1:0] epc,
  output logic         fetch_valid,
  output logic         misalign_err,
  output logic [1:0]   state
);

  pc_state_e    state_q, state_d;
  logic         pc_load, epc_load;
  logic [N-1:0] pc_d, epc_d;
  logic         misalign_d, misalign_q;

  assign pc_plus_inc = pc + N'(INC);

  always_comb begin
    state_d    = state_q;
    pc_load    = 1'b0;
    pc_d       = pc;
    epc_load   = 1'b0;
    epc_d      = pc;
    misalign_d = 1'b0;
    unique case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (exc_req) begin
          pc_load  = 1'b1;
          pc_d     = EXC_VECTOR;
          epc_load = 1'b1;
        end else if (eret) begin
          pc_load = 1'b1;
          pc_d    = epc;
        end else if (jump) begin
          pc_load    = 1'b1;
          pc_d       = {jump_target[N-1:2], 2'b00};
          misalign_d = |jump_target[1:0];
        end else if (branch_taken) begin
          pc_load    = 1'b1;
          pc_d       = {branch_target[N-1:2], 2'b00};
          misalign_d = |branch_target[1:0];
        end else if (halt_req) begin
          state_d = StHalt;
        end else if (enable) begin
          pc_load = 1'b1;
          pc_d    = pc_plus_inc;
        end
      end
      StHalt: begin
        // Only an exception or resume can leave HALT; pc holds otherwise.
        if (exc_req) begin
          pc_load  = 1'b1;
          pc_d     = EXC_VECTOR;
          epc_load = 1'b1;
          state_d  = StRun;
        end else if (resume) begin
          state_d = StRun;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StBoot;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      misalign_q <= misalign_d;
    end
  end

  pc_reg #(
    .N         (N),
    .RESET_VAL (RESET_VECTOR)
  ) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .load  (pc_load),
    .d     (pc_d),
    .q     (pc)
  );

  pc_reg #(
    .N         (N),
    .RESET_VAL ('0)
  ) u_epc_reg (
    .clk   (clk),
    .reset (reset),
    .load  (epc_load),
    .d     (epc_d),
    .q     (epc)
  );

  assign state        = state_q;
  assign misalign_err = misalign_q;
  assign fetch_valid  = (state_q == StRun) && enable;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam logic [31:0] RV  = 32'h0040_0000;
  localparam logic [31:0] EV  = 32'h8000_0180;
  localparam logic [1:0]  SB  = 2'd0;
  localparam logic [1:0]  SR  = 2'd1;
  localparam logic [1:0]  SH  = 2'd2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0, branch_taken = 1'b0, jump = 1'b0;
  logic [31:0] branch_target = '0, jump_target = '0;
  logic        exc_req = 1'b0, eret = 1'b0, halt_req = 1'b0, resume = 1'b0;
  logic [31:0] pc, pc_plus_inc, epc;
  logic        fetch_valid, misalign_err;
  logic [1:0]  state;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .exc_req       (exc_req),
    .eret          (eret),
    .halt_req      (halt_req),
    .resume        (resume),
    .pc            (pc),
    .pc_plus_inc   (pc_plus_inc),
    .epc           (epc),
    .fetch_valid   (fetch_valid),
    .misalign_err  (misalign_err),
    .state         (state)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic [1:0]  st;
    logic        mis;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  // Reference model state.
  logic [31:0] m_pc, m_epc;
  logic [1:0]  m_st;
  logic        m_mis;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) $display("FAIL %s: got %h expected %h", tag, got, want);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_pc = RV; m_epc = '0; m_st = SB; m_mis = 1'b0;
  endtask

  task automatic model_step();
    logic [31:0] npc, nepc;
    logic [1:0]  nst;
    logic        nmis;
    npc = m_pc; nepc = m_epc; nst = m_st; nmis = 1'b0;
    if (m_st == SB) begin
      nst = SR;
    end else if (exc_req) begin
      npc = EV; nepc = m_pc; nst = SR;
    end else if (m_st == SH) begin
      if (resume) nst = SR;
    end else if (eret) begin
      npc = m_epc;
    end else if (jump) begin
      npc = jump_target & 32'hFFFF_FFFC; nmis = (jump_target[1:0] != 2'b00);
    end else if (branch_taken) begin
      npc = branch_target & 32'hFFFF_FFFC; nmis = (branch_target[1:0] != 2'b00);
    end else if (halt_req) begin
      nst = SH;
    end else if (enable) begin
      npc = m_pc + 32'd4;
    end
    m_pc = npc; m_epc = nepc; m_st = nst; m_mis = nmis;
  endtask

  // Drive one cycle of inputs, predict, then compare after the clock edge.
  task automatic drive(input logic en, input logic br, input logic [31:0] bt, input logic j,
                       input logic [31:0] jt, input logic exc, input logic er, input logic hr,
                       input logic rs);
    exp_t e;
    enable = en; branch_taken = br; branch_target = bt; jump = j; jump_target = jt;
    exc_req = exc; eret = er; halt_req = hr; resume = rs;
    #1;
    check("fetch_valid", 32'(fetch_valid), 32'((m_st == SR) && en));
    model_step();
    sb.push_back('{pc: m_pc, epc: m_epc, st: m_st, mis: m_mis});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("pc", pc, e.pc);
      check("epc", epc, e.epc);
      check("state", 32'(state), 32'(e.st));
      check("misalign_err", 32'(misalign_err), 32'(e.mis));
      check("pc_plus_inc", pc_plus_inc, e.pc + 32'd4);
    end
  endtask

  task automatic idle(input logic en);
    drive(en, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_jump(input logic [31:0] t);
    drive(1'b0, 1'b0, '0, 1'b1, t, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc, RV);
    check("rst_epc", epc, 32'd0);
    check("rst_state", 32'(state), 32'(SB));
    check("rst_misalign", 32'(misalign_err), 32'd0);
    check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Boot then sequential advance.
    idle(1'b1);
    check("boot_pc", pc, 32'h0040_0000);
    idle(1'b1);
    idle(1'b1);
    check("seq_pc", pc, 32'h0040_0008);

    // Branch overrides a stall; misaligned target is truncated and pulses.
    drive(1'b0, 1'b1, 32'h0040_1000, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("branch_pc", pc, 32'h0040_1000);
    drive(1'b0, 1'b1, 32'h0040_1002, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("branch_mis", 32'(misalign_err), 32'd1);
    idle(1'b0);
    check("mis_clear", 32'(misalign_err), 32'd0);

    // Exception beats jump; eret returns.
    do_jump(32'h0040_0010);
    drive(1'b1, 1'b0, '0, 1'b1, 32'h0000_1234, 1'b1, 1'b0, 1'b0, 1'b0);
    check("exc_pc", pc, 32'h8000_0180);
    check("exc_epc", epc, 32'h0040_0010);
    idle(1'b1);
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("eret_pc", pc, 32'h0040_0010);

    // Halt holds for 5 cycles, resume, then advance.
    do_jump(32'h0040_0020);
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("halt_state", 32'(state), 32'(SH));
    repeat (5) drive(1'b1, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0200, 1'b0, 1'b1, 1'b0, 1'b0);
    check("halt_hold", pc, 32'h0040_0020);
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    check("resume_pc", pc, 32'h0040_0024);

    // Exception taken from HALT.
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("halt_exc_state", 32'(state), 32'(SR));
    check("halt_exc_epc", epc, 32'h0040_0024);

    // Wrap at the top of the address space.
    do_jump(32'hFFFF_FFFC);
    idle(1'b1);
    check("wrap_pc", pc, 32'h0000_0000);
    check("wrap_mis", 32'(misalign_err), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) == 0), $urandom(),
            1'($urandom_range(0, 7) == 0), $urandom(), 1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 3) == 0));
    end

    // Reset asserted mid-redirect, between clock edges.
    jump = 1'b1; jump_target = 32'h0012_3450; exc_req = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("midrst_pc", pc, RV);
    check("midrst_epc", epc, 32'd0);
    check("midrst_state", 32'(state), 32'(SB));
    check("midrst_mis", 32'(misalign_err), 32'd0);
    check("midrst_fv", 32'(fetch_valid), 32'd0);
    sb.delete();
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    idle(1'b1);
    idle(1'b1);
    check("post_rst_pc", pc, 32'h0040_0004);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter N, default 32: PC/address width in bits.
REQ-002 Parameter RESET_VECTOR, default 32'h0040_0000: PC value loaded by reset.
REQ-003 Parameter EXC_VECTOR, default 32'h8000_0180: PC value loaded on exception.
REQ-004 Parameter INC, default 4: sequential PC increment in bytes.
REQ-005 clk  in  1  system clock; all state changes on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 enable  in  1  1 = PC may advance sequentially; 0 = stall and hold PC.
REQ-008 branch_taken  in  1  redirect to branch_target this cycle.
REQ-009 branch_target  in  N  branch destination address.
REQ-010 jump  in  1  redirect to jump_target this cycle.
REQ-011 jump_target  in  N  jump destination address.
REQ-012 exc_req  in  1  exception request; vector to EXC_VECTOR.
REQ-013 eret  in  1  exception return; load PC from epc.
REQ-014 halt_req  in  1  enter HALT state.
REQ-015 resume  in  1  leave HALT state.
REQ-016 pc  out  N  current fetch address, registered.
REQ-017 pc_plus_inc  out  N  pc + INC, combinational, modulo 2^N.
REQ-018 epc  out  N  saved exception PC, registered.
REQ-019 fetch_valid  out  1  1 when pc is a valid fetch this cycle.
REQ-020 misalign_err  out  1  one-cycle registered pulse on misaligned redirect target.
REQ-021 state  out  2  current FSM state encoding.

Function
REQ-022 FSM states: BOOT, RUN, HALT; BOOT SHALL advance to RUN on the first clock edge after reset deasserts, unconditionally.
REQ-023 In BOOT, all redirect, halt and stall inputs SHALL be ignored and pc SHALL hold RESET_VECTOR.
REQ-024 In RUN, next-PC priority SHALL be: exc_req > eret > jump > branch_taken > halt_req > enable increment > hold.
REQ-025 exc_req: pc <= EXC_VECTOR and epc <= current pc on the same edge, regardless of enable or state (except BOOT).
REQ-026 eret: pc <= epc; epc unchanged.
REQ-027 jump / branch_taken: pc <= target with bits [1:0] forced to 0, regardless of enable; redirects override a stall.
REQ-028 If the selected redirect target has bits [1:0] != 0, misalign_err SHALL be 1 for exactly the next cycle; otherwise 0.
REQ-029 Sequential advance: pc <= pc + INC when enable=1; wraps from 2^N-INC to 0 without error.
REQ-030 halt_req (with no higher-priority event) SHALL move RUN -> HALT with pc held.
REQ-031 In HALT, pc SHALL hold; resume moves HALT -> RUN (pc unchanged); exc_req SHALL take effect from HALT and return the FSM to RUN; other inputs ignored.
REQ-032 fetch_valid SHALL equal (state==RUN) AND enable, combinationally.
REQ-033 Redirect and increment latency SHALL be one cycle: the new pc is visible the cycle after the request.

Reset
REQ-034 While reset=1: pc=RESET_VECTOR, epc=0, state=BOOT, misalign_err=0, fetch_valid=0, asynchronously.
REQ-035 Reset asserted mid-operation (any state, any pending redirect) SHALL abort it and apply REQ-034 immediately.

Structure
REQ-036 Shared package SHALL hold the FSM state encoding (BOOT=0, RUN=1, HALT=2) and the default vector constants.
REQ-037 One sub-module, pc_reg: parametrised N-bit register with asynchronous active-high reset to a parameter value and load enable; used for pc and epc.

Verification
REQ-038 Reset release, enable=1 for 3 cycles -> pc 0x00400000 (BOOT), 0x00400000, 0x00400004, 0x00400008; fetch_valid 0,1,1,1.
REQ-039 enable=0 with branch_taken=1, target=0x00401000 -> pc=0x00401000 next cycle; target 0x00401002 -> pc=0x00401000, misalign_err pulse 1 cycle.
REQ-040 At pc=0x00400010 assert exc_req and jump together -> pc=0x80000180, epc=0x00400010; later eret -> pc=0x00400010.
REQ-041 halt_req at pc=0x00400020 -> state HALT, pc held 5 cycles, fetch_valid=0; resume -> RUN, pc advances to 0x00400024.
REQ-042 N=32, force pc=0xFFFFFFFC via jump, enable=1 -> pc=0x00000000, misalign_err=0.
REQ-043 Assert reset mid-redirect at a non-edge time -> pc=RESET_VECTOR, epc=0, state=BOOT before the next clk edge.
